fetch_unit: RTL and testbench

// Instruction fetch stage directly upstream of the control decoder. Keeps the PC and

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack, prefetch FIFO,
// and a decoded head word presented under valid/ready.
module fetch_unit #(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] instr_pc,
  output logic [5:0]      op,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [15:0]     imm16
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              req_q, req_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       data_q [DEPTH];
  logic [31:0]       data_d [DEPTH];
  logic [PC_W-1:0]   tag_q  [DEPTH];
  logic [PC_W-1:0]   tag_d  [DEPTH];

  logic xfer;
  logic push;
  logic pop;

  assign out_valid = (count_q != '0);
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign instr     = out_valid ? data_q[rd_ptr_q] : '0;
  assign instr_pc  = out_valid ? tag_q[rd_ptr_q]  : '0;
  assign op        = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign imm16     = instr[15:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    tag_d    = tag_q;
    xfer     = req_q && imem_ack;
    push     = 1'b0;
    pop      = 1'b0;

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // An unacked request must still complete on the bus; its data is dropped in DRAIN.
      if (state_q != S_IDLE && !xfer) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    end else begin
      push = (state_q == S_WAIT) && xfer;
      pop  = out_valid && out_ready;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        data_d[wr_ptr_q] = imem_rdata;
        tag_d[wr_ptr_q]  = addr_q;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (en && count_q < DEPTH_C) begin
            state_d = S_WAIT;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
        S_WAIT: begin
          if (xfer) begin
            pc_d = pc_q + 1'b1;
            if (en && count_d < DEPTH_C) begin
              addr_d = pc_q + 1'b1;
            end else begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM responder with programmable ack latency, queue scoreboard
// of the expected in-order stream, field-decode table and multi-cycle corner sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;

  logic        imem_req2;
  logic [7:0]  imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic        out_valid2;
  logic [31:0] instr2;
  logic [7:0]  instr_pc2;
  logic [5:0]  op2;
  logic [4:0]  rs2, rt2, rd2;
  logic [15:0] imm2;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .instr_pc(instr_pc),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16)
  );

  fetch_unit #(.PC_W(8), .DEPTH(2), .RESET_PC(8'hFE)) dut_wrap (
    .clk(clk), .rst(rst), .en(1'b1),
    .redirect_valid(1'b0), .redirect_pc(8'h00),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .out_valid(out_valid2), .out_ready(1'b1),
    .instr(instr2), .instr_pc(instr_pc2),
    .op(op2), .rs(rs2), .rt(rt2), .rd(rd2), .imm16(imm2)
  );

  // ROM responders
  logic [31:0] mem [256];
  int unsigned ack_delay = 0;
  int unsigned req_age   = 0;
  logic        ack_force = 1'b0;

  assign imem_ack    = (imem_req && (req_age >= ack_delay)) || ack_force;
  assign imem_rdata  = mem[imem_addr];
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = 32'hB000_0000 | {24'h0, imem_addr2};

  always @(posedge clk) begin
    if (!imem_req || imem_ack) req_age <= 0;
    else req_age <= req_age + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    chk({nm, "_timeout"}, out_valid, 1);
  endtask

  // Scoreboard: expected in-order stream from the last reset/redirect target
  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] word;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  task automatic refill(input logic [7:0] start);
    logic [7:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back({p, mem[p]});
      p++;
    end
  endtask

  logic [7:0] exp2 [4];
  int idx2 = 0;

  always @(negedge clk) begin
    if (rst) begin
      refill(8'h00);
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = exp_q[0];
          chk("sb_pc", instr_pc, e.pc);
          chk("sb_instr", instr, e.word);
          chk("sb_fields", {op, rs, rt, rd, imm16},
              {e.word[31:26], e.word[25:21], e.word[20:16], e.word[15:11], e.word[15:0]});
          if (out_ready && !redirect_valid) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_zero", {instr, instr_pc, op, rs, rt, rd, imm16}, '0);
      end
      if (redirect_valid) refill(redirect_pc);
      if (out_valid2 && idx2 < 4) begin
        chk("wrap_pc", instr_pc2, exp2[idx2]);
        chk("wrap_instr", instr2, 32'hB000_0000 | {24'h0, exp2[idx2]});
        idx2++;
      end
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } vec_t;
  vec_t vecs [5];

  initial begin
    logic [7:0] a0;
    int n;

    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    vecs[0] = '{8'h10, 32'hFFFF_FFFF, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF};
    vecs[1] = '{8'h20, 32'h0000_0000, 6'h00, 5'h00, 5'h00, 5'h00, 16'h0000};
    vecs[2] = '{8'h30, 32'h8C43_0004, 6'h23, 5'd2,  5'd3,  5'd0,  16'h0004};
    vecs[3] = '{8'h50, 32'h012A_4020, 6'h00, 5'd9,  5'd10, 5'd8,  16'h4020};
    vecs[4] = '{8'h60, 32'hA5A5_A5A5, 6'h29, 5'd13, 5'd5,  5'd20, 16'hA5A5};
    for (int i = 0; i < 5; i++) mem[vecs[i].addr] = vecs[i].word;
    exp2[0] = 8'hFE; exp2[1] = 8'hFF; exp2[2] = 8'h00; exp2[3] = 8'h01;

    rst = 1'b1; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_req2", imem_req2, 0);
    chk("rst_valid2", out_valid2, 0);

    // Zero-wait stream: first valid two cycles after reset release, then one per cycle
    rst = 1'b0; en = 1'b1; out_ready = 1'b1;
    tick();
    chk("t1_valid_c1", out_valid, 0);
    chk("t1_req_c1", imem_req, 1);
    chk("t1_addr_c1", imem_addr, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t1_valid", out_valid, 1);
      chk("t1_pc", instr_pc, i);
      chk("t1_op", op, 6'h28);
      tick();
    end

    // Backpressure: FIFO fills to DEPTH and requests stop
    out_ready = 1'b0;
    repeat (10) tick();
    chk("t2_req_low", imem_req, 0);
    chk("t2_valid", out_valid, 1);
    chk("t2_head", instr_pc, 8'd10);
    out_ready = 1'b1; en = 1'b0;
    tick();
    chk("t2_second", out_valid, 1);
    chk("t2_second_pc", instr_pc, 8'd11);
    tick();
    chk("t2_empty", out_valid, 0);
    chk("t2_req_idle", imem_req, 0);

    // Slow memory: request held stable until the ack
    ack_delay = 3; en = 1'b1;
    n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    chk("t3_req_timeout", imem_req, 1);
    a0 = imem_addr;
    chk("t3_addr", a0, 8'd12);
    for (int k = 0; k < 4; k++) begin
      chk("t3_hold_req", imem_req, 1);
      chk("t3_hold_addr", imem_addr, a0);
      chk("t3_ack", imem_ack, (k == 3));
      tick();
    end
    chk("t3_next_addr", imem_addr, a0 + 8'd1);
    chk("t3_next_req", imem_req, 1);

    // Redirect while waiting on addr 5: drain and discard, restart at 0x40
    redirect_valid = 1'b1; redirect_pc = 8'h05;
    tick();
    redirect_valid = 1'b0;
    n = 0;
    while (!(imem_req && imem_addr == 8'h05 && !imem_ack) && n < 40) begin tick(); n++; end
    chk("t4_wait5_timeout", imem_addr, 8'h05);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t4_flushed", out_valid, 0);
    chk("t4_hold_req", imem_req, 1);
    chk("t4_hold_addr", imem_addr, 8'h05);
    wait_valid("t4");
    chk("t4_first_pc", instr_pc, 8'h40);
    chk("t4_first_instr", instr, 32'hA000_0040);

    // Redirect twice back to back: second lands during DRAIN
    n = 0;
    while (!(imem_req && !imem_ack) && n < 20) begin tick(); n++; end
    chk("t5_wait_timeout", imem_req, 1);
    redirect_valid = 1'b1; redirect_pc = 8'h60;
    tick();
    redirect_pc = 8'h70;
    tick();
    redirect_valid = 1'b0;
    chk("t5_flushed", out_valid, 0);
    wait_valid("t5");
    chk("t5_first_pc", instr_pc, 8'h70);

    // Redirect coinciding with an ack: no drain, request drops immediately
    ack_delay = 0;
    n = 0;
    while (!(imem_req && imem_ack) && n < 20) begin tick(); n++; end
    chk("t6_ack_timeout", imem_ack, 1);
    redirect_valid = 1'b1; redirect_pc = 8'h80;
    tick();
    redirect_valid = 1'b0;
    chk("t6_req_dropped", imem_req, 0);
    wait_valid("t6");
    chk("t6_first_pc", instr_pc, 8'h80);

    // Field decode table
    for (int i = 0; i < 5; i++) begin
      redirect_valid = 1'b1; redirect_pc = vecs[i].addr;
      tick();
      redirect_valid = 1'b0;
      wait_valid("tbl");
      chk("tbl_pc", instr_pc, vecs[i].addr);
      chk("tbl_instr", instr, vecs[i].word);
      chk("tbl_op", op, vecs[i].op);
      chk("tbl_rs", rs, vecs[i].rs);
      chk("tbl_rt", rt, vecs[i].rt);
      chk("tbl_rd", rd, vecs[i].rd);
      chk("tbl_imm", imm16, vecs[i].imm);
    end

    // Reset mid-transfer, with a stray ack while the request is low
    ack_delay = 3;
    n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    tick();
    rst = 1'b1;
    tick();
    chk("t7_req", imem_req, 0);
    chk("t7_addr", imem_addr, 0);
    chk("t7_valid", out_valid, 0);
    chk("t7_pc", instr_pc, 0);
    rst = 1'b0; ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    chk("t7_late_ack", out_valid, 0);
    chk("t7_refetch_req", imem_req, 1);
    chk("t7_refetch_addr", imem_addr, 0);
    wait_valid("t7");
    chk("t7_first_pc", instr_pc, 8'h00);
    chk("t7_first_instr", instr, 32'hA000_0000);
    repeat (4) tick();

    chk("wrap_count", idx2, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
